// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   - RV64 load/store funct3 encodings
//   - LSU FSM state encoding (3 bits)
//   - Bus width constant
package lsu_pkg;

    localparam int LSU_DW = 64;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_WAIT  = 3'd2,
        LSU_DONE  = 3'd3,
        LSU_FAULT = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the LSU.
//   funct3_i, lane_i, we_i   : access type, byte lane (addr[2:0]), store/load
//   wdata_i, rdata_i         : raw store data, raw 64-bit bus read data
//   wstrb_o                  : byte strobes for stores
//   wdata_rep_o              : store data replicated across all lanes
//   ldata_o                  : lane-shifted, sign/zero-extended load result
//   misalign_o, illegal_o    : address not size-aligned / bad funct3
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  lane_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wstrb_o,
    output logic [63:0] wdata_rep_o,
    output logic [63:0] ldata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted     = rdata_i >> {lane_i, 3'b000};
        ldata_o     = shifted;
        wstrb_o     = 8'h00;
        wdata_rep_o = wdata_i;
        misalign_o  = 1'b0;

        case (funct3_i)
            F3_LB:   ldata_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   ldata_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   ldata_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   ldata_o = shifted;
            F3_LBU:  ldata_o = {56'd0, shifted[7:0]};
            F3_LHU:  ldata_o = {48'd0, shifted[15:0]};
            F3_LWU:  ldata_o = {32'd0, shifted[31:0]};
            default: ldata_o = shifted;
        endcase

        // funct3[1:0] encodes access size for both loads and stores
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o     = 8'h01 << lane_i;
                wdata_rep_o = {8{wdata_i[7:0]}};
            end
            2'b01: begin
                wstrb_o     = 8'h03 << lane_i;
                wdata_rep_o = {4{wdata_i[15:0]}};
                misalign_o  = lane_i[0];
            end
            2'b10: begin
                wstrb_o     = 8'h0F << lane_i;
                wdata_rep_o = {2{wdata_i[31:0]}};
                misalign_o  = |lane_i[1:0];
            end
            default: begin
                wstrb_o     = 8'hFF;
                wdata_rep_o = wdata_i;
                misalign_o  = |lane_i;
            end
        endcase
    end

    assign illegal_o = we_i ? funct3_i[2] : (funct3_i == 3'b111);

endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit between EX and MEM.
//   clock, reset            : clock, synchronous active-high reset
//   valid_i/we_i/funct3_i   : op request from EX (sampled only in IDLE)
//   addr_i/wdata_i          : effective address, store data
//   load_data_o             : extended load result, held until next load
//   done_o/fault_o          : completion pulse / fault pulse (with done_o)
//   stall_o                 : hold IF/ID/EX while an access is in flight
//   dmem_*                  : req/gnt/rvalid data-memory bus, 8-byte aligned
module lsu
    import lsu_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid_i,
    input  logic          we_i,
    input  logic [2:0]    funct3_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   load_data_o,
    output logic          done_o,
    output logic          fault_o,
    output logic          stall_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [63:0]   dmem_wdata_o,
    output logic [7:0]    dmem_wstrb_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [63:0]   dmem_rdata_i
);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   load_data_q, load_data_d;

    logic          in_idle;
    logic          al_we;
    logic [2:0]    al_funct3, al_lane;
    logic [7:0]    al_wstrb;
    logic [63:0]   al_wdata, al_ldata;
    logic          al_misalign, al_illegal;

    // In IDLE the checker looks at the incoming op so the fault decision is
    // made on acceptance; otherwise it works on the latched op.
    assign in_idle   = (state_q == LSU_IDLE);
    assign al_we     = in_idle ? we_i          : we_q;
    assign al_funct3 = in_idle ? funct3_i      : funct3_q;
    assign al_lane   = in_idle ? addr_i[2:0]   : addr_q[2:0];

    lsu_align u_align (
        .funct3_i    (al_funct3),
        .lane_i      (al_lane),
        .we_i        (al_we),
        .wdata_i     (wdata_q),
        .rdata_i     (dmem_rdata_i),
        .wstrb_o     (al_wstrb),
        .wdata_rep_o (al_wdata),
        .ldata_o     (al_ldata),
        .misalign_o  (al_misalign),
        .illegal_o   (al_illegal)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;

        case (state_q)
            LSU_IDLE: begin
                if (valid_i) begin
                    we_d     = we_i;
                    funct3_d = funct3_i;
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    state_d  = (al_misalign || al_illegal) ? LSU_FAULT : LSU_REQ;
                end
            end
            LSU_REQ: begin
                // gnt only counts here, so a gnt stuck high cannot complete twice
                if (dmem_gnt_i) state_d = we_q ? LSU_DONE : LSU_WAIT;
            end
            LSU_WAIT: begin
                if (dmem_rvalid_i) begin
                    load_data_d = al_ldata;
                    state_d     = LSU_DONE;
                end
            end
            LSU_DONE:  state_d = LSU_IDLE;
            LSU_FAULT: state_d = LSU_IDLE;
            default:   state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LSU_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 64'd0;
            load_data_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
        end
    end

    logic in_req;
    assign in_req = (state_q == LSU_REQ);

    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req & we_q;
    assign dmem_wstrb_o = (in_req && we_q) ? al_wstrb : 8'h00;
    assign dmem_addr_o  = in_req ? {addr_q[AW-1:3], 3'b000} : '0;
    assign dmem_wdata_o = in_req ? al_wdata : 64'd0;

    assign load_data_o  = load_data_q;
    assign done_o       = (state_q == LSU_DONE) || (state_q == LSU_FAULT);
    assign fault_o      = (state_q == LSU_FAULT);
    assign stall_o      = in_req || (state_q == LSU_WAIT) || (in_idle && valid_i);

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, we_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, wdata_i;
    logic [63:0] load_data_o;
    logic        done_o, fault_o, stall_o;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu #(.AW(64), .DW(64)) dut (
        .clock         (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .load_data_o   (load_data_o),
        .done_o        (done_o),
        .fault_o       (fault_o),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_wstrb_o  (dmem_wstrb_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one op starting at a negedge. gnt comes after gnt_dly extra REQ
    // cycles; rvalid follows one cycle after gnt. During REQ a bogus rvalid
    // is driven for loads, which the unit must ignore.
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd, input int gnt_dly,
                          input logic [63:0] rd, input logic exp_fault,
                          input logic [63:0] exp_ld, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wd);
        valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        #1 chk({tag, ".stall_acc"}, 64'(stall_o), 64'd1);
        @(negedge clk);
        valid_i = 1'b0; addr_i = 64'hDEAD_BEEF_DEAD_BEEF; wdata_i = 64'h5555;
        if (exp_fault) begin
            chk({tag, ".f_req"},   64'(dmem_req_o), 64'd0);
            chk({tag, ".f_done"},  64'(done_o), 64'd1);
            chk({tag, ".f_fault"}, 64'(fault_o), 64'd1);
            chk({tag, ".f_stall"}, 64'(stall_o), 64'd0);
            chk({tag, ".f_ld"},    load_data_o, exp_ld);
            @(negedge clk);
            chk({tag, ".f_done0"}, 64'({done_o, fault_o}), 64'd0);
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            chk({tag, ".req"},   64'(dmem_req_o), 64'd1);
            chk({tag, ".stall"}, 64'(stall_o), 64'd1);
            chk({tag, ".addr"},  dmem_addr_o, {a[63:3], 3'b000});
            chk({tag, ".we"},    64'(dmem_we_o), 64'(we));
            if (we) begin
                chk({tag, ".strb"},  64'(dmem_wstrb_o), 64'(exp_strb));
                chk({tag, ".wdata"}, dmem_wdata_o, exp_wd);
            end else begin
                dmem_rvalid_i = 1'b1; dmem_rdata_i = ~rd;
            end
            if (i == gnt_dly) dmem_gnt_i = 1'b1;
            @(negedge clk);
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        end
        if (!we) begin
            chk({tag, ".w_req"},   64'(dmem_req_o), 64'd0);
            chk({tag, ".w_stall"}, 64'(stall_o), 64'd1);
            chk({tag, ".w_done"},  64'(done_o), 64'd0);
            dmem_rvalid_i = 1'b1; dmem_rdata_i = rd;
            @(negedge clk);
            dmem_rvalid_i = 1'b0;
        end
        chk({tag, ".done"},  64'(done_o), 64'd1);
        chk({tag, ".fault"}, 64'(fault_o), 64'd0);
        chk({tag, ".stall"}, 64'(stall_o), 64'd0);
        chk({tag, ".dreq"},  64'(dmem_req_o), 64'd0);
        if (!we) chk({tag, ".ld"}, load_data_o, exp_ld);
        @(negedge clk);
        chk({tag, ".done0"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0;
        addr_i = 64'd0; wdata_i = 64'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst.outs", 64'({done_o, fault_o, stall_o, dmem_req_o, dmem_we_o}), 64'd0);
        chk("rst.strb", 64'(dmem_wstrb_o), 64'd0);
        chk("rst.ld",   load_data_o, 64'd0);

        //     tag    we    f3      addr            wdata         gd rdata                  flt  exp_ld                 strb   exp_wd
        run_op("ld",  1'b0, 3'b011, 64'h1000, 64'd0,              0, 64'h8877665544332211, 1'b0, 64'h8877665544332211, 8'h00, 64'd0);
        run_op("lb",  1'b0, 3'b000, 64'h1003, 64'd0,              0, 64'h00000000F0000000, 1'b0, 64'hFFFFFFFFFFFFFFF0, 8'h00, 64'd0);
        run_op("lbu", 1'b0, 3'b100, 64'h1003, 64'd0,              0, 64'h00000000F0000000, 1'b0, 64'h00000000000000F0, 8'h00, 64'd0);
        // gnt on the 4th REQ cycle
        run_op("sh",  1'b1, 3'b001, 64'h2006, 64'hABCD,           3, 64'd0,                1'b0, 64'd0, 8'hC0, 64'hABCDABCDABCDABCD);
        run_op("lwm", 1'b0, 3'b010, 64'h3002, 64'd0,              0, 64'd0,                1'b1, 64'h00000000000000F0, 8'h00, 64'd0);
        run_op("s100",1'b1, 3'b100, 64'h4000, 64'h1234,           0, 64'd0,                1'b1, 64'h00000000000000F0, 8'h00, 64'd0);
        run_op("l111",1'b0, 3'b111, 64'h4000, 64'd0,              0, 64'd0,                1'b1, 64'h00000000000000F0, 8'h00, 64'd0);
        run_op("sw",  1'b1, 3'b010, 64'h5004, 64'h12345678,       1, 64'd0,                1'b0, 64'd0, 8'hF0, 64'h1234567812345678);
        run_op("sb",  1'b1, 3'b000, 64'h5005, 64'h7F,             0, 64'd0,                1'b0, 64'd0, 8'h20, 64'h7F7F7F7F7F7F7F7F);
        run_op("sd",  1'b1, 3'b011, 64'h5000, 64'h0123456789ABCDEF,0,64'd0,                1'b0, 64'd0, 8'hFF, 64'h0123456789ABCDEF);
        run_op("sdm", 1'b1, 3'b011, 64'h5004, 64'd1,              0, 64'd0,                1'b1, 64'h00000000000000F0, 8'h00, 64'd0);
        run_op("lhu", 1'b0, 3'b101, 64'h6006, 64'd0,              2, 64'h8001000000000000, 1'b0, 64'h0000000000008001, 8'h00, 64'd0);
        run_op("lh",  1'b0, 3'b001, 64'h6006, 64'd0,              0, 64'h8001000000000000, 1'b0, 64'hFFFFFFFFFFFF8001, 8'h00, 64'd0);
        run_op("lwu", 1'b0, 3'b110, 64'h6004, 64'd0,              0, 64'hDEADBEEF00000000, 1'b0, 64'h00000000DEADBEEF, 8'h00, 64'd0);
        run_op("lw",  1'b0, 3'b010, 64'h6004, 64'd0,              0, 64'hDEADBEEF00000000, 1'b0, 64'hFFFFFFFFDEADBEEF, 8'h00, 64'd0);
        run_op("ldm", 1'b0, 3'b011, 64'h6004, 64'd0,              0, 64'd0,                1'b1, 64'hFFFFFFFFDEADBEEF, 8'h00, 64'd0);

        // gnt held high across a store and the next idle cycles: one completion only
        dmem_gnt_i = 1'b1;
        valid_i = 1'b1; we_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h7000; wdata_i = 64'h1;
        @(negedge clk); valid_i = 1'b0;
        chk("gnthi.req", 64'(dmem_req_o), 64'd1);
        @(negedge clk);
        chk("gnthi.done", 64'(done_o), 64'd1);
        @(negedge clk);
        chk("gnthi.idle", 64'({done_o, dmem_req_o, stall_o}), 64'd0);
        @(negedge clk);
        chk("gnthi.idle2", 64'({done_o, dmem_req_o}), 64'd0);
        dmem_gnt_i = 1'b0;

        // reset while in WAIT, then a stale rvalid arrives
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b011; addr_i = 64'h8000;
        @(negedge clk); valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        @(negedge clk); dmem_gnt_i = 1'b0;
        chk("rw.inwait", 64'({dmem_req_o, stall_o}), 64'b01);
        reset = 1'b1;
        @(negedge clk);
        chk("rw.req0", 64'(dmem_req_o), 64'd0);
        reset = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hCAFE;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk("rw.nodone", 64'({done_o, stall_o, dmem_req_o}), 64'd0);
        chk("rw.ld0",    load_data_o, 64'd0);
        @(negedge clk);
        chk("rw.nodone2", 64'(done_o), 64'd0);
        run_op("ld2", 1'b0, 3'b011, 64'h1008, 64'd0, 0, 64'h1122334455667788, 1'b0, 64'h1122334455667788, 8'h00, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
